// File: rtl/mvu_weight_streamer_pkg.sv
// Shared types and helpers for the MVU weight streamer.
// Also provides the default-config weight word type used by the MVU benches.
package mvu_weight_streamer_pkg;

   typedef enum logic {
      S_IDLE,
      S_STREAM
   } state_t;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

   localparam int unsigned DEF_PE           = 16;
   localparam int unsigned DEF_SIMD         = 6;
   localparam int unsigned DEF_WEIGHT_WIDTH = 4;

   typedef logic [DEF_PE-1:0][DEF_SIMD-1:0][DEF_WEIGHT_WIDTH-1:0]
      weight_word_t;

   function automatic int unsigned byte_align(input int unsigned w);
      return (w + 7) / 8 * 8;
   endfunction

endpackage

// File: rtl/weight_mem.sv
// Simple dual-port weight RAM: one write port, one read port.
// Read data appears two cycles after the read is issued, no reset.
module weight_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 16,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0]  ram [DEPTH];
   logic [AW-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= wr_data;
      if (rd_en) addr_q <= rd_addr;
      rd_data <= ram[addr_q];
   end

endmodule

// File: rtl/mvu_weight_streamer.sv
// Replays the stored NF x SF weight matrix N_REPS times on an AXI-Stream
// master, with credit-based reads feeding a 4-entry output FIFO.
module mvu_weight_streamer
   import mvu_weight_streamer_pkg::*;
#(
   parameter int unsigned MW           = 6,
   parameter int unsigned MH           = 32,
   parameter int unsigned PE           = 16,
   parameter int unsigned SIMD         = 6,
   parameter int unsigned WEIGHT_WIDTH = 4,
   parameter int unsigned N_REPS       = 1,
   localparam int unsigned SF       = MW / SIMD,
   localparam int unsigned NF       = MH / PE,
   localparam int unsigned DEPTH    = NF * SF,
   localparam int unsigned WORD_W   = PE * SIMD * WEIGHT_WIDTH,
   localparam int unsigned STREAM_W = byte_align(WORD_W),
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned RW       = (N_REPS > 1) ? $clog2(N_REPS) : 1
) (
   input  logic                ap_clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [WORD_W-1:0]   wr_data,
   output logic                wr_rdy,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [STREAM_W-1:0] m_axis_weights_tdata,
   output logic                m_axis_weights_tvalid,
   input  logic                m_axis_weights_tready
);

   typedef logic [PE-1:0][SIMD-1:0][WEIGHT_WIDTH-1:0] word_t;

   state_t state, state_nxt;

   logic [AW-1:0]    rd_addr;
   logic [RW-1:0]    rep_cnt;
   logic             issued_all;
   logic             v1, l1, v2, l2;
   word_t            mem_dout;
   word_t            fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last;
   logic [PTR_W-1:0] wp, rp;
   logic [PTR_W:0]   count;
   logic             done_q;

   logic       issue, last_rd, fifo_empty;
   logic [3:0] in_use;
   logic       hs, push, pop, head_last, final_hs;
   word_t      head_data;

   weight_mem #(
      .DEPTH (DEPTH),
      .W     (WORD_W),
      .AW    (AW)
   ) u_mem (
      .clk     (ap_clk),
      .wr_en   (wr_en & wr_rdy),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (issue),
      .rd_addr (rd_addr),
      .rd_data (mem_dout)
   );

   // Credits cover both FIFO entries and the two read pipeline stages.
   assign in_use  = 4'(count) + 4'(v1) + 4'(v2);
   assign issue   = busy && !issued_all && (in_use < 4'(FIFO_DEPTH));
   assign last_rd = (rd_addr == AW'(DEPTH - 1))
                 && (rep_cnt == RW'(N_REPS - 1));

   // An empty FIFO lets fresh read data bypass straight to the port.
   assign fifo_empty = (count == '0);
   assign head_data  = fifo_empty ? mem_dout : fifo_data[rp];
   assign head_last  = fifo_empty ? l2 : fifo_last[rp];

   assign m_axis_weights_tvalid = !fifo_empty || v2;
   assign m_axis_weights_tdata  = m_axis_weights_tvalid
                                ? STREAM_W'(head_data) : '0;

   assign hs       = m_axis_weights_tvalid && m_axis_weights_tready;
   assign push     = v2 && !(fifo_empty && m_axis_weights_tready);
   assign pop      = hs && !fifo_empty;
   assign final_hs = hs && head_last;
   assign done     = done_q;

   always_ff @(posedge ap_clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start)    state_nxt = S_STREAM;
         S_STREAM: if (final_hs) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == S_STREAM);
      wr_rdy = (state == S_IDLE);
   end

   always_ff @(posedge ap_clk) begin
      if (rst) begin
         rd_addr    <= '0;
         rep_cnt    <= '0;
         issued_all <= 1'b0;
         v1         <= 1'b0;
         l1         <= 1'b0;
         v2         <= 1'b0;
         l2         <= 1'b0;
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
         fifo_last  <= '0;
         done_q     <= 1'b0;
      end else begin
         v1     <= issue;
         l1     <= issue && last_rd;
         v2     <= v1;
         l2     <= l1;
         done_q <= final_hs;
         count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         if (push) begin
            fifo_last[wp] <= l2;
            wp            <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         if (state == S_IDLE) issued_all <= 1'b0;
         if (issue) begin
            if (rd_addr == AW'(DEPTH - 1)) begin
               rd_addr <= '0;
               if (last_rd) begin
                  rep_cnt    <= '0;
                  issued_all <= 1'b1;
               end else begin
                  rep_cnt <= rep_cnt + 1'b1;
               end
            end else begin
               rd_addr <= rd_addr + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (push) fifo_data[wp] <= mem_dout;
   end

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Directed + randomized bench for mvu_weight_streamer (2x2x4 config, 3 reps).
// Expected beats come from a word array indexed by beat mod DEPTH.
module tb_mvu_weight_streamer;

   localparam int DEPTH = 4;
   localparam int NREP  = 3;
   localparam int TOTAL = DEPTH * NREP;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        wr_en   = 1'b0;
   logic [1:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        wr_rdy;
   logic        start   = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] tdata;
   logic        tvalid;
   logic        tready  = 1'b1;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [15:0] model [DEPTH];
   logic [15:0] beats [$];
   int          beat_cyc [$];
   int          done_cyc [$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   mvu_weight_streamer #(
      .MW           (4),
      .MH           (4),
      .PE           (2),
      .SIMD         (2),
      .WEIGHT_WIDTH (4),
      .N_REPS       (NREP)
   ) dut (
      .ap_clk                (clk),
      .rst                   (rst),
      .wr_en                 (wr_en),
      .wr_addr               (wr_addr),
      .wr_data               (wr_data),
      .wr_rdy                (wr_rdy),
      .start                 (start),
      .busy                  (busy),
      .done                  (done),
      .m_axis_weights_tdata  (tdata),
      .m_axis_weights_tvalid (tvalid),
      .m_axis_weights_tready (tready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && prev_stall) begin
         chk("hold_valid", tvalid, 1);
         chk("hold_data", tdata, prev_data);
      end
      if (tvalid === 1'b1 && tready) begin
         beats.push_back(tdata);
         beat_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
      prev_stall = (tvalid === 1'b1) && !tready;
      prev_data  = tdata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      beats.delete();
      beat_cyc.delete();
      done_cyc.delete();
   endtask

   task automatic start_run(output int k);
      start = 1'b1;
      k = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      int t = 0;
      while (done_cyc.size() < n && t < budget) begin
         step();
         t++;
      end
      chk({tag, "_done_seen"}, done_cyc.size() >= n, 1);
      repeat (3) step();
   endtask

   task automatic check_seq(input string tag, input int nruns,
                            input bit timed, input int k1, input int k2);
      int n = nruns * TOTAL;
      chk({tag, "_count"}, beats.size(), n);
      for (int i = 0; i < beats.size() && i < n; i++) begin
         chk({tag, "_data"}, beats[i], model[i % DEPTH]);
         if (timed)
            chk({tag, "_cyc"}, beat_cyc[i],
                (i < TOTAL) ? k1 + 3 + i : k2 + 3 + i - TOTAL);
      end
      chk({tag, "_done_n"}, done_cyc.size(), nruns);
      if (timed && done_cyc.size() >= nruns)
         for (int r = 0; r < nruns; r++)
            chk({tag, "_done_cyc"}, done_cyc[r],
                ((r == 0) ? k1 : k2) + 3 + TOTAL);
   endtask

   initial begin
      int k, k2;
      bit held;
      logic [15:0] nv;

      repeat (3) step();
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_rdy", wr_rdy, 1);
      rst = 1'b0;
      step();

      model[0] = 16'h1111;
      model[1] = 16'h2222;
      model[2] = 16'h3333;
      model[3] = 16'h4444;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en   = 1'b1;
         wr_addr = 2'(i);
         wr_data = model[i];
         step();
      end
      wr_en = 1'b0;
      step();
      chk("idle_wr_rdy", wr_rdy, 1);

      // Smoke + replay with tready held high
      clear_mon();
      start_run(k);
      chk("start_busy", busy, 1);
      chk("start_wr_rdy", wr_rdy, 0);
      chk("start_tvalid", tvalid, 0);
      wait_done("smoke", 1, 60);
      check_seq("smoke", 1, 1, k, 0);
      chk("smoke_busy_end", busy, 0);
      chk("smoke_done_end", done, 0);

      // Random backpressure with a long stall
      clear_mon();
      start_run(k);
      held = 1'b0;
      for (int t = 0; t < 400 && done_cyc.size() == 0; t++) begin
         if (!held && beats.size() >= 2) begin
            tready = 1'b0;
            repeat (10) step();
            chk("bp_stall_valid", tvalid, 1);
            held = 1'b1;
         end
         tready = ($urandom_range(0, 9) >= 3);
         step();
      end
      tready = 1'b1;
      repeat (3) step();
      check_seq("bp", 1, 0, 0, 0);

      // Writes during STREAM are ignored
      clear_mon();
      start_run(k);
      step();
      wr_en   = 1'b1;
      wr_addr = 2'd0;
      wr_data = 16'hDEAD;
      step();
      chk("guard_wr_rdy", wr_rdy, 0);
      step();
      wr_en = 1'b0;
      wait_done("guard", 1, 60);
      check_seq("guard", 1, 1, k, 0);

      // Rewrite in IDLE, start the very next cycle
      nv = 16'($urandom);
      model[0] = nv;
      wr_en   = 1'b1;
      wr_addr = 2'd0;
      wr_data = nv;
      step();
      wr_en = 1'b0;
      clear_mon();
      start_run(k);
      wait_done("rewrite", 1, 60);
      if (beats.size() > 0) chk("rewrite_first", beats[0], nv);
      check_seq("rewrite", 1, 1, k, 0);

      model[0] = 16'h1111;
      wr_en   = 1'b1;
      wr_addr = 2'd0;
      wr_data = model[0];
      step();
      wr_en = 1'b0;
      step();

      // Reset mid-stream
      clear_mon();
      start_run(k);
      for (int t = 0; t < 40 && beats.size() < 2; t++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_tvalid", tvalid, 0);
      chk("mid_rst_tdata", tdata, 0);
      chk("mid_rst_busy", busy, 0);
      repeat (10) step();
      chk("mid_rst_no_done", done_cyc.size(), 0);
      chk("mid_rst_idle_valid", tvalid, 0);
      clear_mon();
      start_run(k);
      wait_done("after_rst", 1, 60);
      if (beats.size() > 0) chk("after_rst_first", beats[0], 16'h1111);
      check_seq("after_rst", 1, 1, k, 0);

      // Back-to-back: start on the done cycle
      clear_mon();
      start_run(k);
      for (int t = 0; t < 60 && cyc < k + 3 + TOTAL; t++) step();
      chk("b2b_done_now", done, 1);
      k2 = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("b2b", 2, 80);
      check_seq("b2b", 2, 1, k, k2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
